// File: rtl/serial_rx_producer.sv
// Start/stop-framed serial receiver that presents each completed word on a ready/ack port.
// Optional even parity bit is enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx_producer #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  output logic         ready,
  input  logic         ack,
  output logic [N-1:0] pdata,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic          sin_m;
  logic          sin_s;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitcnt;
  logic [N-1:0]  shift;
  logic          stop_bad;

`ifdef SERIAL_RX_PARITY_EN
  logic par_err;
  assign stop_bad = !sin_s || par_err;
`else
  assign stop_bad = !sin_s;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_m     <= 1'b1;
      sin_s     <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      shift     <= '0;
      ready     <= 1'b0;
      pdata     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      sin_m     <= sin;
      sin_s     <= sin_m;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (ready && ack) ready <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!sin_s) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt    <= '0;
            bitcnt <= '0;
            // Line back high at mid start bit means a glitch, not a frame.
            state  <= sin_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            shift  <= {sin_s, shift[N-1:1]};
            bitcnt <= bitcnt + BW'(1);
            if (bitcnt == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_err <= ^{shift, sin_s};
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            // An ack in this same cycle frees the slot, so the new word may load.
            if (stop_bad) begin
              frame_err <= 1'b1;
            end else if (!ready || ack) begin
              pdata <= shift;
              ready <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_producer.sv
// Directed bench for serial_rx_producer: frame table plus hand-written corner sequences.
module tb_serial_rx_producer;

  localparam int N   = 8;
  localparam int CPB = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Negedges from start-bit launch until ready is visible, and until the stop sample edge.
  localparam int LAT      = 155 + 16 * PAR;
  localparam int STOP_NEG = 154 + 16 * PAR;

  logic         clk = 1'b0;
  logic         rst;
  logic         sin;
  logic         ready;
  logic         ack;
  logic [N-1:0] pdata;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  logic ack_cons, ack_man, cons_en, ack_at_edge;
  assign ack = ack_cons | ack_man;

  serial_rx_producer #(.N(N), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .sin(sin), .ready(ready), .ack(ack),
    .pdata(pdata), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0, ovr_cnt = 0, acc_cnt = 0, wide_err = 0, stab_err = 0;
  logic prev_ready = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
  logic [N-1:0] prev_pdata = '0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) ack_at_edge = ack;

  // Consumer model and pulse/stability monitor.
  always @(negedge clk) begin
    if (frame_err) begin
      if (prev_ferr) wide_err++; else ferr_cnt++;
    end
    if (overrun) begin
      if (prev_ovr) wide_err++; else ovr_cnt++;
    end
    if (prev_ready && ready && pdata !== prev_pdata && !ack_at_edge) stab_err++;
    if (ack_cons) begin
      check("ready_drop_after_ack", {31'b0, ready}, 32'd0);
      ack_cons = 1'b0;
    end else if (cons_en && ready) begin
      ack_cons = 1'b1;
      acc_cnt++;
      if (exp_q.size() == 0) check("unexpected_accept", {24'b0, pdata}, 32'hFFFF_FFFF);
      else check("accept_word", {24'b0, pdata}, {24'b0, exp_q.pop_front()});
    end
    prev_ready = ready;
    prev_ferr  = frame_err;
    prev_ovr   = overrun;
    prev_pdata = pdata;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_bad);
    sin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      sin = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef SERIAL_RX_PARITY_EN
    sin = (^d) ^ par_bad;
    repeat (CPB) @(negedge clk);
`endif
    sin = stop_b;
    repeat (CPB) @(negedge clk);
    sin = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic       cons;
    logic [7:0] data;
    logic       stop_b;
    logic       par_bad;
    int         gap;
    logic       push;
    logic       exp_ready;
    logic [7:0] exp_pdata;
    int         dferr;
    int         dovr;
  } vec_t;

  vec_t vecs[8];
  int   nvec;
  int   f0, o0, a0, n, busy_seen;

  initial begin
    rst = 1'b1; sin = 1'b1; ack_man = 1'b0; ack_cons = 1'b0; cons_en = 1'b0;
    nvec = 0;
    vecs[nvec++] = '{1'b1, 8'h01, 1'b1, 1'b0, 0,  1'b1, 1'b0, 8'h01, 0, 0};
    vecs[nvec++] = '{1'b1, 8'hFE, 1'b1, 1'b0, 40, 1'b1, 1'b0, 8'hFE, 0, 0};
    vecs[nvec++] = '{1'b1, 8'h3C, 1'b0, 1'b0, 40, 1'b0, 1'b0, 8'hFE, 1, 0};
    vecs[nvec++] = '{1'b1, 8'h55, 1'b1, 1'b0, 40, 1'b1, 1'b0, 8'h55, 0, 0};
`ifdef SERIAL_RX_PARITY_EN
    vecs[nvec++] = '{1'b1, 8'h07, 1'b1, 1'b0, 40, 1'b1, 1'b0, 8'h07, 0, 0};
    vecs[nvec++] = '{1'b1, 8'h07, 1'b1, 1'b1, 40, 1'b0, 1'b0, 8'h07, 1, 0};
`endif
    vecs[nvec++] = '{1'b0, 8'h11, 1'b1, 1'b0, 40, 1'b0, 1'b1, 8'h11, 0, 0};
    vecs[nvec++] = '{1'b0, 8'h22, 1'b1, 1'b0, 40, 1'b0, 1'b1, 8'h11, 0, 1};

    #1;
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_pdata", {24'b0, pdata}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_frame_err", {31'b0, frame_err}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    idle(3);
    rst = 1'b0;
    idle(5);

    // Single frame with latency measurement.
    cons_en = 1'b1;
    exp_q.push_back(8'hA5);
    a0 = acc_cnt;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        n = 0;
        while (!ready && n < 400) begin
          @(negedge clk);
          n++;
        end
      end
    join
    check("a5_latency_ok", {31'b0, (n >= LAT - 2 && n <= LAT + 2)}, 1);
    idle(10);
    check("a5_accepts", acc_cnt - a0, 1);
    check("a5_ready", {31'b0, ready}, 0);
    check("a5_pdata", {24'b0, pdata}, 32'hA5);

    for (int i = 0; i < nvec; i++) begin
      cons_en = vecs[i].cons;
      f0 = ferr_cnt; o0 = ovr_cnt; a0 = acc_cnt;
      if (vecs[i].push) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_b, vecs[i].par_bad);
      idle(vecs[i].gap);
      check($sformatf("v%0d_ready", i), {31'b0, ready}, {31'b0, vecs[i].exp_ready});
      check($sformatf("v%0d_pdata", i), {24'b0, pdata}, {24'b0, vecs[i].exp_pdata});
      check($sformatf("v%0d_frame_err", i), ferr_cnt - f0, vecs[i].dferr);
      check($sformatf("v%0d_overrun", i), ovr_cnt - o0, vecs[i].dovr);
      check($sformatf("v%0d_accepts", i), acc_cnt - a0, {31'b0, vecs[i].push});
    end

    // Release the pending 0x11.
    exp_q.push_back(8'h11);
    a0 = acc_cnt;
    cons_en = 1'b1;
    idle(10);
    check("drain_accepts", acc_cnt - a0, 1);

    // ack while ready=0 has no effect.
    ack_man = 1'b1;
    idle(5);
    ack_man = 1'b0;
    idle(2);
    check("stray_ack_ready", {31'b0, ready}, 0);
    check("stray_ack_pdata", {24'b0, pdata}, 32'h11);

    // 3-cycle glitch: brief START, back to IDLE, no pulses.
    f0 = ferr_cnt; o0 = ovr_cnt; busy_seen = 0;
    sin = 1'b0;
    idle(3);
    sin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("glitch_busy_seen", {31'b0, (busy_seen > 0 && busy_seen < 16)}, 1);
    check("glitch_busy_end", {31'b0, busy}, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_ready", {31'b0, ready}, 0);

    // Same-cycle ack and stop sample: new word loads, ready stays high, no overrun.
    cons_en = 1'b0;
    send_frame(8'h3A, 1'b1, 1'b0);
    idle(20);
    check("pre_load_pdata", {24'b0, pdata}, 32'h3A);
    o0 = ovr_cnt;
    fork
      send_frame(8'hC3, 1'b1, 1'b0);
      begin
        repeat (STOP_NEG) @(negedge clk);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
      end
    join
    check("same_cycle_ready", {31'b0, ready}, 1);
    check("same_cycle_pdata", {24'b0, pdata}, 32'hC3);
    check("same_cycle_no_ovr", ovr_cnt - o0, 0);
    exp_q.push_back(8'hC3);
    cons_en = 1'b1;
    idle(10);

    // Async reset mid-data, then clean reception.
    cons_en = 1'b0;
    idle(4);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    check("pre_rst_ready", {31'b0, ready}, 1);
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        repeat (60) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_ready", {31'b0, ready}, 0);
        check("async_rst_pdata", {24'b0, pdata}, 0);
        check("async_rst_busy", {31'b0, busy}, 0);
        check("async_rst_pulses", {30'b0, frame_err, overrun}, 0);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    idle(40);
    check("post_rst_quiet", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    check("post_rst_busy", {31'b0, busy}, 0);
    cons_en = 1'b1;
    exp_q.push_back(8'h77);
    a0 = acc_cnt;
    send_frame(8'h77, 1'b1, 1'b0);
    idle(40);
    check("rx77_accepts", acc_cnt - a0, 1);
    check("rx77_pdata", {24'b0, pdata}, 32'h77);

    check("scoreboard_empty", exp_q.size(), 0);
    check("pulse_width", wide_err, 0);
    check("pdata_stable", stab_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
